// File: rtl/uart_tx_fifo.sv
// UART transmitter with programmable baud prescaler, optional parity, 1/2 stop bits and an input FIFO.
// Back-to-back frames are sent with no idle gap; o_uart and o_busy_flag are registered.
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_data_valid,
    output logic                          o_ready,
    input  logic                          i_parity_enable,
    input  logic                          i_parity_type,
    input  logic                          i_stop_bits,
    input  logic [PRESCALE_WIDTH-1:0]     i_prescale,
    output logic                          o_uart,
    output logic                          o_busy_flag,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [CW-1:0]             FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
    localparam logic [AW-1:0]             PTR_ONE  = AW'(1);
    localparam logic [BW-1:0]             BIT_ONE  = BW'(1);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PS_ZERO  = '0;

    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;

    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [BW-1:0]             r_bit;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_parity;
    logic                      r_par_en;
    logic                      r_stop2;
    logic                      r_stop_second;
    logic                      r_uart;
    logic                      r_busy;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_bit_end;
    logic                      w_last_stop;
    logic [DATA_WIDTH-1:0]     w_head;

    assign o_ready      = (r_count != FULL_CNT);
    assign o_fifo_count = r_count;
    assign o_uart       = r_uart;
    assign o_busy_flag  = r_busy;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = i_data_valid & o_ready;
    assign w_bit_end   = (r_cnt == (r_prescale - PS_ONE));
    assign w_last_stop = ~r_stop2 | r_stop_second;
    // A pop happens either from IDLE or on the very last clock of STOP (back-to-back frames).
    assign w_pop = (r_count != '0) &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_end && w_last_stop));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_prescale    <= PS_ONE;
            r_bit         <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_par_en      <= 1'b0;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_uart        <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + PS_ONE;
            end

            case (r_state)
                IDLE: begin
                    r_uart <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_state <= START;
                        r_uart  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_uart  <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == LAST_BIT) begin
                            r_stop_second <= 1'b0;
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_uart  <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_uart  <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_ONE;
                            r_shift <= r_shift >> 1;
                            r_uart  <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_uart  <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (!w_last_stop) begin
                            r_stop_second <= 1'b1;
                        end else if (w_pop) begin
                            r_state <= START;
                            r_uart  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_uart  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_uart  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            // Word and frame configuration are captured together so mid-frame input changes only affect the next frame.
            if (w_pop) begin
                r_shift       <= w_head;
                r_parity      <= (^w_head) ^ i_parity_type;
                r_prescale    <= (i_prescale == PS_ZERO) ? PS_ONE : i_prescale;
                r_par_en      <= i_parity_enable;
                r_stop2       <= i_stop_bits;
                r_stop_second <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle plus directed literal checks.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_data_valid = 1'b0;
    logic          i_parity_enable = 1'b0;
    logic          i_parity_type = 1'b0;
    logic          i_stop_bits = 1'b0;
    logic [PW-1:0] i_prescale = 16'd1;
    logic          o_ready;
    logic          o_uart;
    logic          o_busy_flag;
    logic [$clog2(DEPTH):0] o_fifo_count;

    int total = 0;
    int bad   = 0;
    int busy_run = 0;
    int last_len = 0;

    int t1_bits [11] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
    int t2_bits [12] = '{0, 1,0,1,0,0,1,0,1, 1, 1, 1};

    uart_tx_fifo #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_ready(o_ready), .i_parity_enable(i_parity_enable), .i_parity_type(i_parity_type),
        .i_stop_bits(i_stop_bits), .i_prescale(i_prescale), .o_uart(o_uart),
        .o_busy_flag(o_busy_flag), .o_fifo_count(o_fifo_count)
    );

    always #5 clk = ~clk;

    // Model: queued words plus a queue of the line level for each upcoming clock of the current frame.
    logic [DW-1:0] mq [$];
    bit            lq [$];
    logic          m_uart = 1'b1;
    logic          m_busy = 1'b0;
    logic [DW-1:0] md;
    bit            mpush;
    int            mp;

    function automatic void add_bit(bit v, int n);
        for (int k = 0; k < n; k++) lq.push_back(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            lq.delete();
            m_uart = 1'b1;
            m_busy = 1'b0;
        end else begin
            mpush = i_data_valid && (mq.size() < DEPTH);
            if (lq.size() == 0 && mq.size() > 0) begin
                md = mq.pop_front();
                mp = (i_prescale == 0) ? 1 : int'(i_prescale);
                add_bit(1'b0, mp);
                for (int b = 0; b < DW; b++) add_bit(md[b], mp);
                if (i_parity_enable) add_bit((^md) ^ i_parity_type, mp);
                add_bit(1'b1, i_stop_bits ? 2 * mp : mp);
            end
            if (mpush) mq.push_back(i_data);
            if (lq.size() > 0) begin
                m_uart = lq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_uart = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every wait goes through here: compare against the model, then track busy run length.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            busy_run = 0;
        end else begin
            chk("uart", int'(o_uart), int'(m_uart));
            chk("busy", int'(o_busy_flag), int'(m_busy));
            chk("ready", int'(o_ready), (mq.size() < DEPTH) ? 1 : 0);
            chk("count", int'(o_fifo_count), mq.size());
            if (o_busy_flag) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_len = busy_run;
                busy_run = 0;
            end
        end
    endtask

    task automatic push1(input logic [DW-1:0] d);
        i_data = d;
        i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            if (!o_busy_flag && o_fifo_count == 0) done = 1;
        end
        chk("idle_timeout", int'(done), 1);
    endtask

    initial begin
        bit any_busy;
        repeat (2) tick();
        chk("rst_uart", int'(o_uart), 1);
        chk("rst_busy", int'(o_busy_flag), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_count", int'(o_fifo_count), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Frame 0xA5, P=4, even parity, 1 stop
        i_prescale = 16'd4; i_parity_enable = 1'b1; i_parity_type = 1'b0; i_stop_bits = 1'b0;
        push1(8'hA5);
        tick(); tick();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1_bit%0d", i), int'(o_uart), t1_bits[i]);
            repeat (4) tick();
        end
        wait_idle();
        chk("t1_busy_len", last_len, 44);

        // Odd parity, 2 stop bits
        i_parity_type = 1'b1; i_stop_bits = 1'b1;
        push1(8'hA5);
        tick(); tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_bit%0d", i), int'(o_uart), t2_bits[i]);
            repeat (4) tick();
        end
        wait_idle();
        chk("t2_busy_len", last_len, 48);

        // Prescale 0 behaves as 1
        i_prescale = 16'd0; i_parity_enable = 1'b0; i_parity_type = 1'b0; i_stop_bits = 1'b0;
        push1(8'h00);
        wait_idle();
        chk("t3_busy_len", last_len, 10);

        // Burst of 5 pushes into depth-4 FIFO, then a dropped push while full
        i_prescale = 16'd2;
        i_data_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_data = 8'h30 + 8'(k * 7);
            chk($sformatf("t4_ready%0d", k), int'(o_ready), 1);
            tick();
        end
        i_data = 8'hEE;
        chk("t4_full_ready", int'(o_ready), 0);
        chk("t4_full_count", int'(o_fifo_count), 4);
        tick();
        i_data_valid = 1'b0;
        chk("t4_drop_count", int'(o_fifo_count), 4);
        wait_idle();
        chk("t4_busy_len", last_len, 100);

        // Prescale change mid-frame applies to the next frame only
        i_prescale = 16'd4;
        i_data_valid = 1'b1;
        i_data = 8'h3C; tick();
        i_data = 8'hC3; tick();
        i_data_valid = 1'b0;
        repeat (10) tick();
        i_prescale = 16'd2;
        wait_idle();
        chk("t5_busy_len", last_len, 60);

        // Reset in the middle of DATA with 2 words queued
        i_prescale = 16'd4;
        i_data_valid = 1'b1;
        i_data = 8'h11; tick();
        i_data = 8'h22; tick();
        i_data = 8'h33; tick();
        i_data_valid = 1'b0;
        repeat (12) tick();
        chk("t6_pre_count", int'(o_fifo_count), 2);
        chk("t6_pre_busy", int'(o_busy_flag), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_uart", int'(o_uart), 1);
        chk("t6_rst_busy", int'(o_busy_flag), 0);
        chk("t6_rst_count", int'(o_fifo_count), 0);
        chk("t6_rst_ready", int'(o_ready), 1);
        tick();
        rst = 1'b0;
        any_busy = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_busy_flag || !o_uart) any_busy = 1;
        end
        chk("t6_no_restart", int'(any_busy), 0);
        push1(8'h5A);
        wait_idle();
        chk("t6_busy_len", last_len, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
